serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 135 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/sub sequencer driving one external 1-bit full-adder cell, LSB first.
// Latency: start accepted at edge k, done=1 from edge k+WIDTH; minimum issue interval WIDTH+2.
// Backpressure: result held with done=1 until ack; start ignored unless ready=1 (IDLE).
// Optional: `define SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             done,
    input  logic             ack
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             carry;
    logic [CW-1:0]    cnt;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/adder-cell outputs; adder inputs come only from registers.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_cin    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                fa_a   = sh_a[0];
                fa_b   = sh_b[0];
                fa_cin = carry;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand load at start, then one bit per clock; subtraction is A + ~B + 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_a      <= '0;
            sh_b      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= op_a;
                        sh_b  <= sub ? ~op_b : op_b;
                        carry <= sub;
                        cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    result <= {fa_sum, result[WIDTH-1:1]};
                    carry  <= fa_cout;
                    sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
                    sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        carry_out <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                        // MSB carry-in differs from carry-out: signed overflow.
                        ovf       <= fa_cin ^ fa_cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector bench for serial_add_ctrl with a behavioural full-adder cell.
// Latency: checks done arrives WIDTH cycles after the start edge.
// Backpressure: exercises held done with late ack and ignored start/ack.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         ready;
    logic         busy;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_sum;
    logic         fa_cout;
    logic [W-1:0] result;
    logic         carry_out;
    logic         done;
    logic         ack;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_total = 0;
    int n_bad   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .ready     (ready),
        .busy      (busy),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_sum    (fa_sum),
        .fa_cout   (fa_cout),
        .result    (result),
        .carry_out (carry_out),
        .done      (done),
        .ack       (ack)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // External full-adder cell
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for done; returns cycles after the start edge.
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic cin_seen);
        start = 1'b1;
        sub   = s;
        op_a  = a;
        op_b  = b;
        tick();
        start    = 1'b0;
        lat      = 0;
        cin_seen = 1'b0;
        while (!done && lat < 40) begin
            cin_seen = cin_seen | fa_cin;
            tick();
            lat++;
        end
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({tag, "_ready_after_ack"}, 32'(ready), 32'd1);
        chk({tag, "_done_after_ack"}, 32'(done), 32'd0);
    endtask

    task automatic op_check(input string tag, input logic s, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic exp_c);
        int   lat;
        logic cs;
        run_op(s, a, b, lat, cs);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(W));
        chk({tag, "_result"}, 32'(result), 32'(exp_r));
        chk({tag, "_carry"}, 32'(carry_out), 32'(exp_c));
    endtask

    initial begin
        int   lat;
        logic cs;

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        ack   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);

        // Ack outside DONE is ignored
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("idle_ack_ready", 32'(ready), 32'd1);
        chk("idle_ack_done", 32'(done), 32'd0);

        // 1: basic add with handshake visibility
        start = 1'b1; sub = 1'b0; op_a = 8'h5A; op_b = 8'h3C;
        tick();
        start = 1'b0;
        chk("t1_ready_low", 32'(ready), 32'd0);
        chk("t1_busy_high", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_lat", 32'(lat), 32'd8);
        chk("t1_busy_low", 32'(busy), 32'd0);
        chk("t1_result", 32'(result), 32'h96);
        chk("t1_carry", 32'(carry_out), 32'd0);
        chk("t1_fa_idle", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        do_ack("t1");

        // 2: carry out and all-zero add
        op_check("t2a", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1);
        do_ack("t2a");
        run_op(1'b0, 8'h00, 8'h00, lat, cs);
        chk("t2b_done", 32'(done), 32'd1);
        chk("t2b_result", 32'(result), 32'h00);
        chk("t2b_carry", 32'(carry_out), 32'd0);
        chk("t2b_cin_never", 32'(cs), 32'd0);
        do_ack("t2b");

        // 3: subtraction with and without borrow
        op_check("t3a", 1'b1, 8'h10, 8'h01, 8'h0F, 1'b1);
        do_ack("t3a");
        op_check("t3b", 1'b1, 8'h01, 8'h02, 8'hFF, 1'b0);
        do_ack("t3b");

        // 4: start during RUN and DONE ignored; done held without ack
        start = 1'b1; sub = 1'b0; op_a = 8'h21; op_b = 8'h13;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; sub = 1'b1; op_a = 8'hFF; op_b = 8'hFF;
        tick();
        start = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk("t4_lat", 32'(lat), 32'd8);
        chk("t4_result", 32'(result), 32'h34);
        start = 1'b1; op_a = 8'h77; op_b = 8'h01;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            chk("t4_hold_done", 32'(done), 32'd1);
            chk("t4_hold_result", 32'(result), 32'h34);
            chk("t4_hold_ready", 32'(ready), 32'd0);
        end
        do_ack("t4");

        // 5: reset after bit 3 aborts the operation
        start = 1'b1; sub = 1'b0; op_a = 8'hAA; op_b = 8'h55;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_ready", 32'(ready), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_result", 32'(result), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("t5_no_done", 32'(done), 32'd0);
        op_check("t5b", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0);
        do_ack("t5b");

        // 6: signed-overflow cases
        op_check("t6a", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        chk("t6a_ovf", 32'(ovf), 32'd1);
`endif
        do_ack("t6a");
        op_check("t6b", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
        chk("t6b_ovf", 32'(ovf), 32'd1);
`endif
        do_ack("t6b");
        op_check("t6c", 1'b0, 8'h10, 8'h10, 8'h20, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        chk("t6c_ovf", 32'(ovf), 32'd0);
`endif
        do_ack("t6c");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
